// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: shares one SPI master transmitter among NUM_REQ requesters.
// A round-robin pick latches the winner's payload and device index, fires a
// one-cycle start pulse, follows m_busy to completion (with a timeout abort)
// and returns a one-cycle acknowledge, then idles for GAP_CYCLES cycles.
// Optional build macro SPI_ARB_PRIO0_EN: requester 0 gets fixed top priority
// and the others rotate among themselves.
module spi_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int SEL_W      = 2,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      m_tx_enable,
    output logic [DATA_W-1:0]         m_data,
    input  logic                      m_busy,
    output logic [SEL_W-1:0]          dev_sel,
    output logic                      err
);

    // Timeout counter only has to hold 0..TIMEOUT-1; abort fires when the
    // next increment would reach TIMEOUT.
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 m_tx_enable_q, m_tx_enable_d;
    logic [DATA_W-1:0]    m_data_q, m_data_d;
    logic [SEL_W-1:0]     dev_sel_q, dev_sel_d;
    logic                 err_q, err_d;
    logic [SEL_W-1:0]     last_q, last_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;

    // Per-requester payload view of the flat data bus.
    logic [DATA_W-1:0]    data_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_data
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [NUM_REQ-1:0]   rr_req;
    logic                 win_valid;
    logic [SEL_W-1:0]     win_idx;
    logic                 win_upd;

    // Winner selection: first requester above the pointer, wrapping around.
    always_comb begin
        int idx;
        idx       = 0;
        rr_req    = req;
`ifdef SPI_ARB_PRIO0_EN
        rr_req[0] = 1'b0;
`endif
        win_valid = 1'b0;
        win_idx   = '0;
        win_upd   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!win_valid && (|(rr_req & (NUM_REQ'(1) << idx)))) begin
                win_valid = 1'b1;
                win_idx   = SEL_W'(idx);
                win_upd   = 1'b1;
            end
        end
`ifdef SPI_ARB_PRIO0_EN
        // Requester 0 overrides the rotation and leaves the pointer alone.
        if (req[0]) begin
            win_valid = 1'b1;
            win_idx   = '0;
            win_upd   = 1'b0;
        end
`endif
    end

    // Next-state and output logic for the transaction sequencer.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        ack_d         = '0;
        err_d         = 1'b0;
        m_tx_enable_d = 1'b0;
        m_data_d      = m_data_q;
        dev_sel_d     = dev_sel_q;
        last_d        = last_q;
        to_cnt_d      = to_cnt_q;
        gap_cnt_d     = gap_cnt_q;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    gnt_d         = NUM_REQ'(1) << win_idx;
                    dev_sel_d     = win_idx;
                    m_data_d      = data_arr[win_idx];
                    m_tx_enable_d = 1'b1;
                    if (win_upd) begin
                        last_d = win_idx;
                    end
                    to_cnt_d      = '0;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                to_cnt_d = '0;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY, WAIT_DONE: begin
                if ((state_q == WAIT_BUSY) && m_busy) begin
                    to_cnt_d = '0;
                    state_d  = WAIT_DONE;
                end else if ((state_q == WAIT_DONE) && !m_busy) begin
                    ack_d     = gnt_q;
                    gnt_d     = '0;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else if (to_cnt_q == TO_LAST) begin
                    // Abort: the master is left alone, only our side is released.
                    ack_d     = gnt_q;
                    err_d     = 1'b1;
                    gnt_d     = '0;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            ack_q         <= '0;
            m_tx_enable_q <= 1'b0;
            m_data_q      <= '0;
            dev_sel_q     <= '0;
            err_q         <= 1'b0;
            last_q        <= SEL_W'(NUM_REQ - 1);
            to_cnt_q      <= '0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            ack_q         <= ack_d;
            m_tx_enable_q <= m_tx_enable_d;
            m_data_q      <= m_data_d;
            dev_sel_q     <= dev_sel_d;
            err_q         <= err_d;
            last_q        <= last_d;
            to_cnt_q      <= to_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign gnt         = gnt_q;
    assign ack         = ack_q;
    assign m_tx_enable = m_tx_enable_q;
    assign m_data      = m_data_q;
    assign dev_sel     = dev_sel_q;
    assign err         = err_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Testbench for spi_req_arbiter: directed scenarios plus a randomized run,
// checked against a transaction-level model of the arbitration rules and
// the expected timing of grant, start, acknowledge and timeout.
module tb_spi_req_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_W     = 8;
    localparam int SEL_W      = 2;
    localparam int GAP_CYCLES = 2;
    localparam int TIMEOUT    = 255;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        ack;
    logic                      m_tx_enable;
    logic [DATA_W-1:0]         m_data;
    logic                      m_busy;
    logic [SEL_W-1:0]          dev_sel;
    logic                      err;

    int checks    = 0;
    int errors    = 0;
    int txen_cnt  = 0;
    bit mst_en    = 1'b0;
    int busy_delay = 2;
    int busy_len   = 4;
    int mdl_last   = NUM_REQ - 1;

    spi_req_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .SEL_W(SEL_W),
        .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .ack(ack), .m_tx_enable(m_tx_enable), .m_data(m_data),
        .m_busy(m_busy), .dev_sel(dev_sel), .err(err)
    );

    always #5 clk = ~clk;

    // Count start pulses in the middle of each cycle.
    always @(negedge clk) begin
        if (m_tx_enable === 1'b1) txen_cnt <= txen_cnt + 1;
    end

    // SPI master model: busy rises busy_delay cycles after the start pulse
    // and stays high for busy_len cycles.
    initial begin
        m_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (m_tx_enable === 1'b1 && mst_en) begin
                repeat (busy_delay) @(posedge clk);
                #1 m_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 m_busy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first pending requester above the last winner.
    function automatic int pick(input logic [NUM_REQ-1:0] r, input int last);
`ifdef SPI_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx = (last + k) % NUM_REQ;
`ifdef SPI_ARB_PRIO0_EN
            if (idx == 0) continue;
`endif
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    // One full transaction. upd: 0 keep req, 1 drop served bit,
    // 2 drop served bit and add random new requests, 3 clear all.
    task automatic do_txn(input int dly, input int len, input bit mst_on, input int upd,
                          input bit withdraw, input int exp_wait);
        int w, n, e, exp_e, base;
        bit exp_err, hold_ok;
        logic [NUM_REQ-1:0] oh, nb;
        logic [DATA_W-1:0]  exp_data;
        busy_delay = dly;
        busy_len   = len;
        mst_en     = mst_on;
        w = pick(req, mdl_last);
        if (w < 0) begin
            chk("req_pending", 32'(req), 32'hF);
            return;
        end
        oh       = NUM_REQ'(1) << w;
        exp_data = req_data[w*DATA_W +: DATA_W];
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) begin
                chk("ack_one_cycle", 32'(ack), 0);
                chk("err_one_cycle", 32'(err), 0);
            end
        end while (gnt === '0 && n < 40);
        if (gnt === '0) begin
            chk("grant_wait", 32'(gnt), 32'(oh));
            return;
        end
        chk("gnt", 32'(gnt), 32'(oh));
        chk("dev_sel", 32'(dev_sel), w);
        chk("m_data", 32'(m_data), 32'(exp_data));
        chk("m_tx_enable", 32'(m_tx_enable), 1);
        if (exp_wait > 0) chk("grant_latency", n, exp_wait);
`ifdef SPI_ARB_PRIO0_EN
        if (w != 0) mdl_last = w;
`else
        mdl_last = w;
`endif
        base = txen_cnt;
        if (!mst_on) begin
            exp_e = TIMEOUT + 1;        exp_err = 1'b1;
        end else if (len > TIMEOUT) begin
            exp_e = dly + 1 + TIMEOUT;  exp_err = 1'b1;
        end else begin
            exp_e = dly + len + 1;      exp_err = 1'b0;
        end
        e = 0;
        hold_ok = 1'b1;
        while (e < exp_e + 20) begin
            tick();
            e++;
            if (ack !== '0) break;
            if (gnt !== oh || m_tx_enable !== 1'b0 || err !== 1'b0 ||
                dev_sel !== SEL_W'(w) || m_data !== exp_data) hold_ok = 1'b0;
            if (withdraw && e == dly + 2) req[w] = 1'b0;
        end
        chk("hold_during_txn", 32'(hold_ok), 1);
        if (ack === '0) begin
            chk("ack_wait", 32'(ack), 32'(oh));
            return;
        end
        chk("ack", 32'(ack), 32'(oh));
        chk("err", 32'(err), 32'(exp_err));
        chk("gnt_cleared", 32'(gnt), 0);
        chk("ack_cycle", e, exp_e);
        chk("tx_en_count", txen_cnt - base, 1);
        chk("dev_sel_kept", 32'(dev_sel), w);
        chk("m_data_kept", 32'(m_data), 32'(exp_data));
        $display("txn: winner=%0d data=%0h dly=%0d len=%0d ack_after=%0d err=%0b",
                 w, exp_data, dly, len, e, err);
        case (upd)
            1: req[w] = 1'b0;
            2: begin
                req[w] = 1'b0;
                nb = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1)) & ~req;
                for (int i = 0; i < NUM_REQ; i++)
                    if (nb[i]) req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                req = req | nb;
            end
            3: req = '0;
            default: ;
        endcase
    endtask

    initial begin
        int n, t0;
        bit quiet;
        rst = 1'b1;
        req = '0;
        req_data = '0;
        repeat (3) tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_tx_en", 32'(m_tx_enable), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_dev_sel", 32'(dev_sel), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        mdl_last = NUM_REQ - 1;
        tick();

        // Single request.
        req_data[15:8] = 8'h18;
        req = 4'b0010;
        do_txn(2, 40, 1'b1, 1, 1'b0, 1);
        repeat (GAP_CYCLES + 2) tick();

        // Contention after reset with all requests held.
        rst = 1'b1; tick(); rst = 1'b0;
        mdl_last = NUM_REQ - 1;
        req_data = 32'hA3A2_A1A0;
        req = 4'b1111;
        do_txn(2, 3, 1'b1, 0, 1'b0, 1);
        for (int i = 0; i < 4; i++)
            do_txn(1 + i % 3, 3, 1'b1, (i == 3) ? 3 : 0, 1'b0, GAP_CYCLES + 1);
        repeat (GAP_CYCLES + 2) tick();

        // Timeout waiting for busy, then a normal request.
        req = 4'b0100;
        do_txn(1, 1, 1'b0, 3, 1'b0, 1);
        repeat (GAP_CYCLES + 2) tick();
        req_data[7:0] = 8'h5C;
        req = 4'b0001;
        do_txn(3, 5, 1'b1, 3, 1'b0, 1);
        repeat (GAP_CYCLES + 2) tick();

        // Timeout while busy never falls.
        req = 4'b0010;
        do_txn(2, TIMEOUT + 20, 1'b1, 3, 1'b0, 1);
        n = 0;
        while (m_busy === 1'b1 && n < 100) begin tick(); n++; end
        repeat (GAP_CYCLES + 2) tick();

        // Reset in the middle of a transfer.
        req = 4'b0010;
        busy_delay = 2; busy_len = 20; mst_en = 1'b1;
        tick();
        chk("rstmid_gnt", 32'(gnt), 32'h2);
        repeat (4) tick();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
        chk("rstmid_gnt0", 32'(gnt), 0);
        chk("rstmid_ack0", 32'(ack), 0);
        chk("rstmid_tx_en0", 32'(m_tx_enable), 0);
        chk("rstmid_m_data0", 32'(m_data), 0);
        chk("rstmid_dev_sel0", 32'(dev_sel), 0);
        chk("rstmid_err0", 32'(err), 0);
        quiet = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ack !== '0 || err !== 1'b0 || gnt !== '0) quiet = 1'b0;
        end
        chk("rstmid_no_ack", 32'(quiet), 1);
        n = 0;
        while (m_busy === 1'b1 && n < 100) begin tick(); n++; end
        mdl_last = NUM_REQ - 1;
        req_data = 32'h3300_0011;
        req = 4'b1000;
        do_txn(2, 6, 1'b1, 1, 1'b0, 1);
        req = 4'b1001;
        do_txn(2, 6, 1'b1, 1, 1'b0, GAP_CYCLES + 1);
        do_txn(2, 6, 1'b1, 3, 1'b0, GAP_CYCLES + 1);
        repeat (GAP_CYCLES + 2) tick();

        // Request withdrawn during WAIT_DONE.
        req_data[31:24] = 8'hC7;
        req = 4'b1000;
        do_txn(2, 10, 1'b1, 1, 1'b1, 1);
        t0 = txen_cnt;
        repeat (GAP_CYCLES + 6) tick();
        chk("withdraw_no_gnt", 32'(gnt), 0);
        chk("withdraw_no_restart", txen_cnt - t0, 0);

        // Three requesters held, then requester 0 leaves.
        req_data = 32'h0044_3322;
        req = 4'b0111;
        do_txn(1, 2, 1'b1, 0, 1'b0, 1);
        do_txn(1, 2, 1'b1, 0, 1'b0, GAP_CYCLES + 1);
        do_txn(1, 2, 1'b1, 0, 1'b0, GAP_CYCLES + 1);
        req = 4'b0110;
        for (int i = 0; i < 4; i++)
            do_txn(2, 2, 1'b1, (i == 3) ? 3 : 0, 1'b0, GAP_CYCLES + 1);

        // Randomized traffic.
        for (int t = 0; t < 25; t++) begin
            int ew;
            if (req == '0) begin
                repeat (GAP_CYCLES + 3) tick();
                req = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
                for (int i = 0; i < NUM_REQ; i++)
                    if (req[i]) req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                ew = 1;
            end else begin
                ew = GAP_CYCLES + 1;
            end
            do_txn(int'($urandom_range(1, 4)), int'($urandom_range(1, 10)), 1'b1, 2, 1'b0, ew);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
Shares a single SPI master transmitter among NUM_REQ requesters. Round-robin arbitration picks one request, which is latched and launched into the master with a one-cycle start pulse. The block follows the master's busy signal to completion and returns a per-requester acknowledge. It sits between the client logic and the spi master, and drives the device-select index used to decode per-slave chip selects.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, width of one SPI payload byte
SEL_W, 2, width of dev_sel; must be at least clog2(NUM_REQ)
GAP_CYCLES, 2, idle clk cycles enforced between transactions (0 allowed)
TIMEOUT, 255, max clk cycles spent in WAIT_BUSY or WAIT_DONE before abort

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester request level; held until ack
req_data  input  NUM_REQ*DATA_W  payload; requester i uses bits [i*DATA_W +: DATA_W]
gnt  output  NUM_REQ  one-hot grant, held for the whole transaction
ack  output  NUM_REQ  one-cycle completion pulse to the granted requester
m_tx_enable  output  1  one-cycle start pulse to the spi master
m_data  output  DATA_W  latched payload to the master
m_busy  input  1  master busy: high from start_en until return to idle
dev_sel  output  SEL_W  index of the granted requester
err  output  1  one-cycle pulse, coincident with ack, on timeout abort

Behaviour:
- Reset: clk and rst are as stated above; rst is synchronous and active-high. On reset, gnt=0, ack=0, m_tx_enable=0, m_data=0, dev_sel=0, err=0, state=IDLE, timeout counter=0, gap counter=0. The round-robin pointer last resets to NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, GRANT, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if req!=0, the winner is the first set bit searching upward from last+1, with wrap-around. On the next edge:
  - gnt[w]=1, dev_sel=w, m_data=req_data[w], last=w.
  - Transition to GRANT.
  - Latency from req rising to gnt is 1 cycle.
- GRANT, 1 cycle: m_tx_enable=1 for exactly this cycle, then WAIT_BUSY.
- WAIT_BUSY: wait for m_busy=1, then WAIT_DONE and clear the timeout counter.
- WAIT_DONE: wait for m_busy=0, then:
  - ack[w]=1 for one cycle, gnt cleared in the same edge.
  - Transition to GAP, or to IDLE if GAP_CYCLES=0.
- GAP: count GAP_CYCLES cycles with gnt=0, then IDLE. Requests arriving during GAP are held off and arbitrated in IDLE.
- Timeout: the counter increments each cycle in WAIT_BUSY/WAIT_DONE. When it reaches TIMEOUT:
  - ack[w] and err pulse together for one cycle, gnt is cleared, go to GAP.
  - The master is not reset by this block.
- m_data and dev_sel stay stable from GRANT until the next grant; they are not cleared on completion.
- Simultaneous requests: resolved only by the pointer. A requester that was just served is last in line, so no requester is starved while others hold req.
- req withdrawn mid-transaction: ignored; the transaction runs to ack. req withdrawn in IDLE before the grant edge: that requester is not selected.
- Reset mid-operation: takes effect at the next edge regardless of state. Any pending ack or err is suppressed, and m_tx_enable is dropped.
- m_busy high while IDLE, with no grant outstanding: ignored.

Optional Feature:
Macro SPI_ARB_PRIO0_EN.
- Defined: requester 0 has fixed highest priority. If req[0]=1 in IDLE it wins regardless of the pointer, and the pointer is not updated. Requesters 1..NUM_REQ-1 rotate among themselves.
- Undefined: pure round-robin over all NUM_REQ requesters, as described in Behaviour.

Test Plan:
- Single request: req=4'b0010, req_data[15:8]=8'h18, master model raises busy 2 cycles after start and holds it 40 cycles -> gnt=4'b0010 and dev_sel=1 one cycle after req; m_tx_enable pulses once with m_data=8'h18; ack[1] pulses the cycle after busy falls.
- Contention after reset: req=4'b1111 held, payloads 8'hA0..8'hA3 -> grant order 0,1,2,3,0. Gap between ack and the next gnt is exactly GAP_CYCLES+1 cycles.
- Timeout: m_busy tied 0, req=4'b0100 -> after GRANT plus 255 cycles, ack[2] and err pulse together, then gnt=0. The next request is served normally.
- Reset mid-transfer: assert rst for 1 cycle during WAIT_DONE -> all outputs return to 0 next edge with no ack. After release, a req=4'b1000 request is granted requester 3; with req=4'b1001, requester 0 wins first.
- Late withdrawal: req[3] dropped in WAIT_DONE -> ack[3] is still pulsed and no second m_tx_enable occurs.
- With SPI_ARB_PRIO0_EN: req=4'b0111 held -> grant order 0,0,0...; drop req[0] -> order 1,2,1,2.
